uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Configurable UART transmitter, next generation of the team's fixed 8-bit even-parity transmitter.
- Adds the following, all latched per frame:
  - DATA_W-bit payload.
  - Runtime parity mode: none, even or odd.
  - 1 or 2 stop bits.
  - A one-cycle completion pulse.
- Sits between a host write port and the TxD pin.
- Runs entirely on clk, using a clock-enable tick from an internal baud tick generator. The FSM is not clocked by the tick.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; sets baud divisors.
- DATA_W, 8, payload bits per frame; legal range 5..9.
- OVERSAMPLE, 16, ticks per bit period.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- Tx_DATA, input, DATA_W, payload; sampled on write acceptance.
- Tx_WR, input, 1, write request; level-sampled each clk.
- Tx_EN, input, 1, transmitter enable.
- baud_select, input, 3, baud rate code.
- parity_sel, input, 2, parity mode: 00 none, 01 even, 10 odd, 11 none.
- stop2, input, 1, 0 = one stop bit, 1 = two stop bits.
- TxD, output, 1, serial line, idle high.
- Tx_BUSY, output, 1, frame in progress.
- Tx_DONE, output, 1, one-clk pulse when the last stop bit period ends.

Behaviour:
- Reset (reset=0, asynchronous):
  - TxD=1, Tx_BUSY=0, Tx_DONE=0.
  - FSM=IDLE; all counters, shift register and parity accumulator cleared.
  - Baud divider counter cleared.
  - Takes effect mid-frame immediately; no partial frame resumes after reset releases.
- Baud tick generation:
  - baud_select 0..7 maps to 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud.
  - div = round(CLK_HZ / (OVERSAMPLE * baud)), minimum 1.
  - The tick is a one-clk pulse every div clks.
  - The tick generator restarts at write acceptance, so the start bit lasts exactly OVERSAMPLE*div clks.
- Write acceptance:
  - A write is accepted on a clk edge with state=IDLE, Tx_EN=1 and Tx_WR=1.
  - On acceptance: latch Tx_DATA, parity_sel and stop2; state goes to START; Tx_BUSY=1 and TxD=0 take effect on the next clk edge output (1 clk latency).
  - Tx_WR while Tx_BUSY=1 is ignored. No queueing, no error flag.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each non-IDLE state holds TxD for OVERSAMPLE ticks; a 4-bit tick counter wraps at OVERSAMPLE-1.
  - START: TxD=0.
  - DATA: TxD=data[bit_idx], LSB first, bit_idx 0..DATA_W-1. Parity accumulates the XOR of the bits sent.
  - PARITY: entered only when parity is enabled. Even mode sends XOR of data bits; odd mode sends its inverse. When parity is disabled, DATA goes directly to STOP.
  - STOP: TxD=1 for 1 or 2 bit periods, per latched stop2.
  - At the end of STOP: Tx_DONE=1 for exactly one clk, Tx_BUSY=0, state=IDLE.
  - A write asserted in the same clk as Tx_DONE is not accepted. It is accepted the next clk if Tx_WR is still high, giving back-to-back frames with a 1-clk gap.
- Frame length, acceptance to Tx_DONE: (1 + DATA_W + P + S) * OVERSAMPLE * div clks, where P is 0/1 (parity) and S is 1/2 (stop bits).
- Tx_EN:
  - Tx_EN=0 blocks new acceptance.
  - A frame already in progress completes normally.
  - In IDLE, TxD=1 regardless of Tx_EN.
- Runtime inputs: changes to baud_select, parity_sel or stop2 during a frame do not affect that frame. baud_select takes effect at the next acceptance.
- TxD is registered; no combinational path from any input to TxD.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding localparams.
  - Parity code localparams: PAR_NONE, PAR_EVEN, PAR_ODD.
  - The baud rate table, as a function returning the divisor from CLK_HZ, OVERSAMPLE and baud_select.
- One sub-module: uart_baud_tick, which takes clk, reset, baud_select and restart and produces the tick.

Test Plan:
- All tests use CLK_HZ=1_843_200, baud_select=3'b111, so div=1 and 16 clks per bit.
- Reset values: hold reset=0 with random inputs -> TxD=1, Tx_BUSY=0, Tx_DONE=0. Release -> TxD stays 1.
- 8N1, Tx_DATA=8'hA5, parity_sel=00, stop2=0, Tx_WR pulse:
  - TxD=0 one clk after acceptance, for 16 clks.
  - Then bits 1,0,1,0,0,1,0,1 at 16 clks each, then 1 for 16 clks.
  - Tx_DONE pulses at acceptance+160 clks; Tx_BUSY falls in the same clk.
- Parity, 8'hA5: even (01) -> parity bit 0; odd (10) -> parity bit 1. With stop2=1, Tx_DONE comes at acceptance+192 clks.
- DATA_W=5 build, Tx_DATA=5'h13, even parity -> bits 1,1,0,0,1, parity 1, frame 128 clks.
- Write while busy: second Tx_WR with 8'h3C at clk 40 of a frame -> ignored; first frame is unchanged.
- Tx_WR held high -> second frame's start bit begins 1 clk after the first frame's Tx_DONE.
- Tx_EN dropped at clk 50 of a frame -> frame completes to Tx_DONE; a following Tx_WR with Tx_EN=0 is ignored and TxD stays 1.
- reset=0 at clk 70 of a frame -> TxD=1 and Tx_BUSY=0 immediately (asynchronous). After release, IDLE; no residual bits are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
// Latency: n/a (types, constants and a constant-time divisor helper).
// Backpressure: n/a.
package uart_pkg;

   // FSM state encodings
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_START  = S_START,
      ST_DATA   = S_DATA,
      ST_PARITY = S_PARITY,
      ST_STOP   = S_STOP
   } tx_state_t;

   // Parity mode codes; 2'b11 is treated as no parity
   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   // Width of the baud divisor; covers 300 baud at several hundred MHz
   localparam int DIV_W = 24;

   // Rounded clocks-per-tick for a baud code, clamped to [1, 2^DIV_W-1].
   // Only ever called with constant arguments so no divider is built.
   function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                 input int unsigned oversample,
                                                 input logic [2:0]  sel);
      logic [63:0] baud;
      logic [63:0] den;
      logic [63:0] q;
      case (sel)
         3'd0:    baud = 64'd300;
         3'd1:    baud = 64'd1200;
         3'd2:    baud = 64'd4800;
         3'd3:    baud = 64'd9600;
         3'd4:    baud = 64'd19200;
         3'd5:    baud = 64'd38400;
         3'd6:    baud = 64'd57600;
         default: baud = 64'd115200;
      endcase
      den = 64'(oversample) * baud;
      q   = (64'(clk_hz) + den / 64'd2) / den;
      if (q == 64'd0)
         q = 64'd1;
      if (q > 64'd16777215)
         q = 64'd16777215;
      return q[DIV_W-1:0];
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud clock-enable generator: one-clk tick every div clks, div picked from baud_select.
// Latency: first tick div clks after restart; divisor is latched at restart.
// Backpressure: none; free-running between restarts.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       restart,
   output logic       tick
);

   localparam logic [DIV_W-1:0] DIV_TAB [8] = '{
      baud_div(CLK_HZ, OVERSAMPLE, 3'd0), baud_div(CLK_HZ, OVERSAMPLE, 3'd1),
      baud_div(CLK_HZ, OVERSAMPLE, 3'd2), baud_div(CLK_HZ, OVERSAMPLE, 3'd3),
      baud_div(CLK_HZ, OVERSAMPLE, 3'd4), baud_div(CLK_HZ, OVERSAMPLE, 3'd5),
      baud_div(CLK_HZ, OVERSAMPLE, 3'd6), baud_div(CLK_HZ, OVERSAMPLE, 3'd7)
   };

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt_q;

   assign tick = (cnt_q == div_q - DIV_W'(1));

   // Divider counter; restart realigns the bit grid to the write acceptance
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
         div_q <= DIV_W'(1);
      end else if (restart) begin
         cnt_q <= '0;
         div_q <= DIV_TAB[baud_select];
      end else if (tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W payload, none/even/odd parity, 1 or 2 stop bits.
// Latency: TxD start bit 1 clk after acceptance; Tx_DONE (1+DATA_W+P+S)*OVERSAMPLE*div clks after.
// Backpressure: single frame in flight; writes while busy or disabled are dropped.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int DATA_W     = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] Tx_DATA,
   input  logic              Tx_WR,
   input  logic              Tx_EN,
   input  logic [2:0]        baud_select,
   input  logic [1:0]        parity_sel,
   input  logic              stop2,
   output logic              TxD,
   output logic              Tx_BUSY,
   output logic              Tx_DONE
);

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] BIT_LAST  = 4'(DATA_W - 1);

   tx_state_t         state_q, state_d;
   logic [3:0]        tick_cnt_q, tick_cnt_d;
   logic [3:0]        bit_idx_q, bit_idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_acc_q, par_acc_d;
   logic [1:0]        par_mode_q, par_mode_d;
   logic              stop2_q, stop2_d;
   logic              stop_cnt_q, stop_cnt_d;
   logic              txd_q, txd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic accept;
   logic baud_tick;
   logic bit_end;
   logic par_en;
   logic par_final;
   logic par_bit;

   assign accept  = (state_q == ST_IDLE) && Tx_EN && Tx_WR;
   assign bit_end = baud_tick && (tick_cnt_q == TICK_LAST);

   // Parity is taken over all data bits including the one finishing now
   assign par_en    = (par_mode_q == PAR_EVEN) || (par_mode_q == PAR_ODD);
   assign par_final = par_acc_q ^ shift_q[0];
   assign par_bit   = (par_mode_q == PAR_ODD) ? ~par_final : par_final;

   assign TxD     = txd_q;
   assign Tx_BUSY = busy_q;
   assign Tx_DONE = done_q;

   uart_baud_tick #(
      .CLK_HZ     (CLK_HZ),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_baud_tick (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .restart     (accept),
      .tick        (baud_tick)
   );

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      par_acc_d  = par_acc_q;
      par_mode_d = par_mode_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;
      txd_d      = txd_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      if ((state_q != ST_IDLE) && baud_tick)
         tick_cnt_d = bit_end ? 4'd0 : tick_cnt_q + 4'd1;

      case (state_q)
         ST_IDLE: begin
            txd_d  = 1'b1;
            busy_d = 1'b0;
            if (accept) begin
               state_d    = ST_START;
               shift_d    = Tx_DATA;
               par_mode_d = parity_sel;
               stop2_d    = stop2;
               tick_cnt_d = 4'd0;
               bit_idx_d  = 4'd0;
               par_acc_d  = 1'b0;
               stop_cnt_d = 1'b0;
               txd_d      = 1'b0;
               busy_d     = 1'b1;
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               par_acc_d = par_final;
               shift_d   = shift_q >> 1;
               if (bit_idx_q == BIT_LAST) begin
                  if (par_en) begin
                     state_d = ST_PARITY;
                     txd_d   = par_bit;
                  end else begin
                     state_d = ST_STOP;
                     txd_d   = 1'b1;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
                  txd_d     = shift_q[1];
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               txd_d   = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  txd_d   = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset forces the line idle mid-frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= 4'd0;
         bit_idx_q  <= 4'd0;
         shift_q    <= '0;
         par_acc_q  <= 1'b0;
         par_mode_q <= PAR_NONE;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         par_acc_q  <= par_acc_d;
         par_mode_q <= par_mode_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         txd_q      <= txd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg with 8-bit and 5-bit builds at 16 clks per bit.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_cfg;

   localparam int CLK_HZ = 1_843_200;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_en = 1'b0;
   logic       wr8 = 1'b0;
   logic       wr5 = 1'b0;
   logic       stop2 = 1'b0;
   logic [1:0] par_sel = 2'b00;
   logic [2:0] baud_sel = 3'b111;
   logic [7:0] data8 = 8'h00;
   logic [4:0] data5 = 5'h00;

   logic txd8, busy8, done8;
   logic txd5, busy5, done5;

   logic sel5 = 1'b0;
   logic txd_m, busy_m, done_m;

   always #5 clk = ~clk;

   assign txd_m  = sel5 ? txd5  : txd8;
   assign busy_m = sel5 ? busy5 : busy8;
   assign done_m = sel5 ? done5 : done8;

   uart_tx_cfg #(.CLK_HZ(CLK_HZ), .DATA_W(8), .OVERSAMPLE(16)) dut8 (
      .clk(clk), .reset(rst_n), .Tx_DATA(data8), .Tx_WR(wr8), .Tx_EN(tx_en),
      .baud_select(baud_sel), .parity_sel(par_sel), .stop2(stop2),
      .TxD(txd8), .Tx_BUSY(busy8), .Tx_DONE(done8)
   );

   uart_tx_cfg #(.CLK_HZ(CLK_HZ), .DATA_W(5), .OVERSAMPLE(16)) dut5 (
      .clk(clk), .reset(rst_n), .Tx_DATA(data5), .Tx_WR(wr5), .Tx_EN(tx_en),
      .baud_select(baud_sel), .parity_sel(par_sel), .stop2(stop2),
      .TxD(txd5), .Tx_BUSY(busy5), .Tx_DONE(done5)
   );

   typedef struct {
      logic [15:0] bits;
      int          nbits;
   } frame_t;

   frame_t exp_q[$];
   int     n_chk = 0;
   int     n_fail = 0;
   int     b2b_seen = 0;
   logic   mon_en = 1'b1;
   logic   mon_act = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Expected line levels, one entry per bit period, start bit first
   function automatic frame_t make_frame(input logic [8:0] d, input int w,
                                         input logic [1:0] par, input logic s2);
      frame_t f;
      logic   p;
      int     n;
      f.bits = '0;
      p = 1'b0;
      for (int i = 0; i < w; i++) begin
         f.bits[1+i] = d[i];
         p = p ^ d[i];
      end
      n = 1 + w;
      if (par == 2'b01) begin
         f.bits[n] = p;
         n++;
      end else if (par == 2'b10) begin
         f.bits[n] = ~p;
         n++;
      end
      f.bits[n] = 1'b1;
      n++;
      if (s2) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits = n;
      return f;
   endfunction

   // Frame decoder: aligns on the start bit and checks both ends of every bit period
   initial begin : monitor
      bit     carry;
      bit     was_carry;
      frame_t f;
      carry = 1'b0;
      forever begin
         if (!carry) @(negedge clk);
         was_carry = carry;
         carry = 1'b0;
         if (rst_n && mon_en && txd_m == 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("spurious_start", 1, 0);
               for (int k = 0; k < 400 && txd_m == 1'b0; k++) @(negedge clk);
            end else begin
               mon_act = 1'b1;
               f = exp_q.pop_front();
               if (was_carry) b2b_seen++;
               for (int k = 0; k < f.nbits * 16; k++) begin
                  if (k % 16 == 0)
                     chk($sformatf("bit%0d_first", k / 16), txd_m, f.bits[k/16]);
                  if (k % 16 == 15)
                     chk($sformatf("bit%0d_last", k / 16), txd_m, f.bits[k/16]);
                  if (k == f.nbits * 16 - 1) begin
                     chk("busy_before_done", busy_m, 1);
                     chk("done_early", done_m, 0);
                  end
                  @(negedge clk);
               end
               chk("done_pulse", done_m, 1);
               chk("busy_fall", busy_m, 0);
               chk("txd_idle_at_done", txd_m, 1);
               @(negedge clk);
               chk("done_width", done_m, 0);
               carry = 1'b1;
               mon_act = 1'b0;
            end
         end
      end
   end

   task automatic drain();
      int k;
      k = 0;
      while ((exp_q.size() != 0 || mon_act) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", int'(k < 2000), 1);
      repeat (40) @(negedge clk);
   endtask

   // One-clk write pulse; config inputs are scrambled right after acceptance
   task automatic send8(input logic [7:0] d, input logic [1:0] p, input logic s2,
                        input bit expect_frame);
      @(negedge clk);
      data8 = d;
      par_sel = p;
      stop2 = s2;
      wr8 = 1'b1;
      if (expect_frame) exp_q.push_back(make_frame({1'b0, d}, 8, p, s2));
      @(negedge clk);
      wr8 = 1'b0;
      data8 = ~d;
      par_sel = ~p;
      stop2 = ~s2;
   endtask

   task automatic idle_watch(input string tag, input int cycles);
      int lows;
      int busys;
      lows = 0;
      busys = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (txd8 !== 1'b1) lows++;
         if (busy8 !== 1'b0) busys++;
      end
      chk({tag, "_txd_low_cycles"}, lows, 0);
      chk({tag, "_busy_cycles"}, busys, 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k;

      // Reset with random inputs
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         tx_en = 1'($urandom);
         wr8 = 1'($urandom);
         wr5 = 1'($urandom);
         data8 = 8'($urandom);
         data5 = 5'($urandom);
         par_sel = 2'($urandom);
         stop2 = 1'($urandom);
         #1;
         chk("rst_txd8", txd8, 1);
         chk("rst_busy8", busy8, 0);
         chk("rst_done8", done8, 0);
         chk("rst_txd5", txd5, 1);
         chk("rst_busy5", busy5, 0);
      end
      @(negedge clk);
      wr8 = 1'b0;
      wr5 = 1'b0;
      tx_en = 1'b1;
      baud_sel = 3'b111;
      par_sel = 2'b00;
      stop2 = 1'b0;
      rst_n = 1'b1;
      idle_watch("post_reset", 5);

      // 8N1, then parity and stop-bit variants
      send8(8'hA5, 2'b00, 1'b0, 1'b1);
      drain();
      send8(8'hA5, 2'b01, 1'b0, 1'b1);
      drain();
      send8(8'hA5, 2'b10, 1'b1, 1'b1);
      drain();
      send8(8'h00, 2'b10, 1'b0, 1'b1);
      drain();
      send8(8'hFF, 2'b11, 1'b1, 1'b1);
      drain();

      // 5-bit build, even parity
      sel5 = 1'b1;
      @(negedge clk);
      data5 = 5'h13;
      par_sel = 2'b01;
      stop2 = 1'b0;
      wr5 = 1'b1;
      exp_q.push_back(make_frame({4'b0, 5'h13}, 5, 2'b01, 1'b0));
      @(negedge clk);
      wr5 = 1'b0;
      par_sel = 2'b10;
      drain();
      sel5 = 1'b0;

      // Write while busy is dropped
      send8(8'h5A, 2'b00, 1'b0, 1'b1);
      repeat (39) @(negedge clk);
      data8 = 8'h3C;
      wr8 = 1'b1;
      @(negedge clk);
      wr8 = 1'b0;
      drain();

      // Tx_WR held high: second start bit right after Tx_DONE
      b2b_seen = 0;
      @(negedge clk);
      data8 = 8'h96;
      par_sel = 2'b01;
      stop2 = 1'b0;
      exp_q.push_back(make_frame({1'b0, 8'h96}, 8, 2'b01, 1'b0));
      exp_q.push_back(make_frame({1'b0, 8'h96}, 8, 2'b01, 1'b0));
      wr8 = 1'b1;
      k = 0;
      while (done8 !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      chk("b2b_first_done_timeout", int'(k < 400), 1);
      @(negedge clk);
      wr8 = 1'b0;
      drain();
      chk("b2b_gap", b2b_seen, 1);

      // Tx_EN dropped mid-frame: frame completes, later writes are blocked
      send8(8'hC3, 2'b10, 1'b0, 1'b1);
      repeat (49) @(negedge clk);
      tx_en = 1'b0;
      drain();
      @(negedge clk);
      data8 = 8'h00;
      wr8 = 1'b1;
      @(negedge clk);
      wr8 = 1'b0;
      idle_watch("en_off", 200);
      tx_en = 1'b1;

      // Asynchronous reset mid-frame
      mon_en = 1'b0;
      send8(8'hA5, 2'b00, 1'b0, 1'b0);
      repeat (70) @(negedge clk);
      chk("pre_reset_txd", txd8, 0);
      chk("pre_reset_busy", busy8, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_txd", txd8, 1);
      chk("async_reset_busy", busy8, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle_watch("after_reset", 300);
      mon_en = 1'b1;

      // Transmitter still works after the mid-frame reset
      send8(8'h3C, 2'b01, 1'b1, 1'b1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
